hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline interlock/forwarding controller; the reader of the ID and EX per-operand want/need flags.
//  Compares ID/EX source regs against EX/M/WB destinations; drives forwarding mux selects and a stall chain IF<-ID<-EX<-M.
//  Tracks the multi-cycle MUL/DIV unit so HI/LO reads interlock until the result is ready.
// PARAMETERS
//  MUL_CYCLES  4   busy cycles after a MULT/MULTU start
//  DIV_CYCLES  32  busy cycles after a DIV/DIVU start
// PORTS
//  CLK            in   1  clock
//  RST            in   1  asynchronous, active-high reset
//  ID_DP_Hazards  in   8  {WantRsID,NeedRsID,WantRtID,NeedRtID,WantRsEX,NeedRsEX,WantRtEX,NeedRtEX} of ID instr
//  ID_Rs, ID_Rt   in   5  ID source regs
//  EX_Rs, EX_Rt   in   5  EX source regs
//  EX_WantRs/EX_NeedRs/EX_WantRt/EX_NeedRt  in 1 each  EX-registered hazard flags
//  EX_RtRd        in   5  EX destination reg;  EX_RegWrite, EX_MemRead  in 1
//  M_RtRd         in   5  M destination reg;   M_RegWrite, M_MemRead    in 1
//  WB_RtRd        in   5  WB destination reg;  WB_RegWrite              in 1
//  IF_Busy        in   1  fetch not ready;  M_Busy  in 1  data memory not ready
//  EX_MulDivStart in   1  MUL/DIV issuing from EX this cycle;  EX_IsDiv  in 1  1=divide
//  EX_ReadHiLo    in   1  EX instr reads HI/LO (MFHI/MFLO)
//  ID_RsFwdSel, ID_RtFwdSel  out 2  00 regfile, 01 EX ALU result, 10 M result, 11 WB data
//  EX_RsFwdSel, EX_RtFwdSel  out 2  00 ID/EX register, 01 M ALU result, 10 WB data
//  IF_Stall, ID_Stall, EX_Stall, M_Stall  out 1  stage hold
//  MulDivBusy     out  1  HI/LO result pending
// BEHAVIOUR
//  match(a,b) = (a==b) && (a!=0); $zero never forwards or stalls.
//  EX fwd (per Rs, likewise Rt): Want & match(EX_Rs,M_RtRd) & M_RegWrite & !M_MemRead -> 01;
//   else Want & match(EX_Rs,WB_RtRd) & WB_RegWrite -> 10; else 00. M beats WB.
//  ID fwd: Want(ID) & match vs EX(EX_RegWrite & !EX_MemRead) -> 01; else M(M_RegWrite & !M_MemRead) -> 10;
//   else WB(WB_RegWrite) -> 11; else 00. Youngest producer wins; a load match suppresses older-stage forward.
//  EX hazard: NeedEX & match(M) & M_RegWrite & M_MemRead (load data not ready), or EX_ReadHiLo & MulDivBusy.
//  ID hazard: NeedID & match(EX) & EX_RegWrite; or NeedID & match(M) & M_RegWrite & M_MemRead.
//  Stall chain (combinational): M_Stall=M_Busy; EX_Stall=M_Stall|EX hazard; ID_Stall=EX_Stall|ID hazard;
//   IF_Stall=ID_Stall|IF_Busy. Stall never asserted by a WB-stage match.
//  MUL/DIV counter cnt (width clog2(max(MUL,DIV)+1)): on edge with EX_MulDivStart & !EX_Stall,
//   cnt<=EX_IsDiv?DIV_CYCLES:MUL_CYCLES (restart overrides a pending op); else if cnt!=0, cnt<=cnt-1.
//   MulDivBusy=(cnt!=0): high exactly N cycles following the start cycle. Start while EX_Stall ignored.
//  Reset: RST async clears cnt (and perf counter); while RST high all stalls=0, all FwdSel=00, MulDivBusy=0.
//  Latency: stalls/selects combinational same cycle; only cnt is registered.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds output StallCycles [31:0]; increments each cycle ID_Stall=1 and RST=0,
//   saturates at 32'hFFFF_FFFF, cleared by RST.
//  Not defined: no port, no counter logic.
// TESTING
//  Load-use: M_MemRead=1,M_RegWrite=1,M_RtRd=5,EX_Rs=5,NeedRsEX -> EX/ID/IF_Stall=1; next cycle WB_RtRd=5 -> stalls 0, EX_RsFwdSel=10.
//  ALU fwd: M_RtRd=3 (ALU), WB_RtRd=3, EX_Rt=3 WantRtEX -> EX_RtFwdSel=01, no stall.
//  Zero reg: all dests=0, sources=0, all Want/Need=1 -> all FwdSel=00, all stalls 0.
//  Branch: NeedRsID, ID_Rs=7=EX_RtRd, EX_RegWrite -> ID_Stall=1, EX_Stall=0; EX_MemRead=0 also gives ID_RsFwdSel=01.
//  DIV: start with EX_IsDiv=1, EX_ReadHiLo=1 next cycle -> EX_Stall=1 for exactly 32 cycles, then 0.
//  Reset mid-DIV at cnt=10 -> MulDivBusy and EX_Stall drop to 0 without a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding control for the ID/EX/M/WB pipeline, plus MUL/DIV busy tracking.
// Optional: define HAZARD_PERF_CNT_EN to add the StallCycles counter output.
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  ID_DP_Hazards,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  EX_Rs,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_WantRs,
    input  logic        EX_NeedRs,
    input  logic        EX_WantRt,
    input  logic        EX_NeedRt,
    input  logic [4:0]  EX_RtRd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  M_RtRd,
    input  logic        M_RegWrite,
    input  logic        M_MemRead,
    input  logic [4:0]  WB_RtRd,
    input  logic        WB_RegWrite,
    input  logic        IF_Busy,
    input  logic        M_Busy,
    input  logic        EX_MulDivStart,
    input  logic        EX_IsDiv,
    input  logic        EX_ReadHiLo,
    output logic [1:0]  ID_RsFwdSel,
    output logic [1:0]  ID_RtFwdSel,
    output logic [1:0]  EX_RsFwdSel,
    output logic [1:0]  EX_RtFwdSel,
    output logic        IF_Stall,
    output logic        ID_Stall,
    output logic        EX_Stall,
    output logic        M_Stall,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] StallCycles,
`endif
    output logic        MulDivBusy
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

    function automatic logic match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    // Youngest matching producer decides; a load there blocks older forwards.
    function automatic logic [1:0] id_fwd(input logic want,
                                          input logic hit_ex, input logic ld_ex,
                                          input logic hit_m, input logic ld_m,
                                          input logic hit_wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (want) begin
            if (hit_ex)
                sel = ld_ex ? 2'b00 : 2'b01;
            else if (hit_m)
                sel = ld_m ? 2'b00 : 2'b10;
            else if (hit_wb)
                sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic [1:0] ex_fwd(input logic want,
                                          input logic hit_m_alu,
                                          input logic hit_wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (want) begin
            if (hit_m_alu)
                sel = 2'b01;
            else if (hit_wb)
                sel = 2'b10;
        end
        return sel;
    endfunction

    logic       want_rs_id;
    logic       need_rs_id;
    logic       want_rt_id;
    logic       need_rt_id;
    logic [3:0] unused_ex_flags;

    assign want_rs_id      = ID_DP_Hazards[7];
    assign need_rs_id      = ID_DP_Hazards[6];
    assign want_rt_id      = ID_DP_Hazards[5];
    assign need_rt_id      = ID_DP_Hazards[4];
    assign unused_ex_flags = ID_DP_Hazards[3:0];

    logic id_rs_ex, id_rs_m, id_rs_wb;
    logic id_rt_ex, id_rt_m, id_rt_wb;
    logic ex_rs_m, ex_rs_wb;
    logic ex_rt_m, ex_rt_wb;

    assign id_rs_ex = match(ID_Rs, EX_RtRd) && EX_RegWrite;
    assign id_rs_m  = match(ID_Rs, M_RtRd)  && M_RegWrite;
    assign id_rs_wb = match(ID_Rs, WB_RtRd) && WB_RegWrite;
    assign id_rt_ex = match(ID_Rt, EX_RtRd) && EX_RegWrite;
    assign id_rt_m  = match(ID_Rt, M_RtRd)  && M_RegWrite;
    assign id_rt_wb = match(ID_Rt, WB_RtRd) && WB_RegWrite;
    assign ex_rs_m  = match(EX_Rs, M_RtRd)  && M_RegWrite;
    assign ex_rs_wb = match(EX_Rs, WB_RtRd) && WB_RegWrite;
    assign ex_rt_m  = match(EX_Rt, M_RtRd)  && M_RegWrite;
    assign ex_rt_wb = match(EX_Rt, WB_RtRd) && WB_RegWrite;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy;
    logic          ex_haz;
    logic          id_haz;
    logic          m_stall;
    logic          ex_stall;
    logic          id_stall;
    logic          if_stall;

    assign busy = (cnt_q != '0);

    assign ex_haz = (EX_NeedRs && ex_rs_m && M_MemRead)
                  || (EX_NeedRt && ex_rt_m && M_MemRead)
                  || (EX_ReadHiLo && busy);

    assign id_haz = (need_rs_id && (id_rs_ex || (id_rs_m && M_MemRead)))
                  || (need_rt_id && (id_rt_ex || (id_rt_m && M_MemRead)));

    assign m_stall  = M_Busy;
    assign ex_stall = m_stall || ex_haz;
    assign id_stall = ex_stall || id_haz;
    assign if_stall = id_stall || IF_Busy;

    // Everything is forced quiet while reset is held.
    always_comb begin
        ID_RsFwdSel = 2'b00;
        ID_RtFwdSel = 2'b00;
        EX_RsFwdSel = 2'b00;
        EX_RtFwdSel = 2'b00;
        M_Stall     = 1'b0;
        EX_Stall    = 1'b0;
        ID_Stall    = 1'b0;
        IF_Stall    = 1'b0;
        MulDivBusy  = 1'b0;
        if (!RST) begin
            ID_RsFwdSel = id_fwd(want_rs_id, id_rs_ex, EX_MemRead,
                                 id_rs_m, M_MemRead, id_rs_wb);
            ID_RtFwdSel = id_fwd(want_rt_id, id_rt_ex, EX_MemRead,
                                 id_rt_m, M_MemRead, id_rt_wb);
            EX_RsFwdSel = ex_fwd(EX_WantRs, ex_rs_m && !M_MemRead, ex_rs_wb);
            EX_RtFwdSel = ex_fwd(EX_WantRt, ex_rt_m && !M_MemRead, ex_rt_wb);
            M_Stall     = m_stall;
            EX_Stall    = ex_stall;
            ID_Stall    = id_stall;
            IF_Stall    = if_stall;
            MulDivBusy  = busy;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (EX_MulDivStart && !ex_stall)
            cnt_d = EX_IsDiv ? DIV_N : MUL_N;
        else if (busy)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    always_comb begin
        perf_d = perf_q;
        if (id_stall && (perf_q != 32'hFFFF_FFFF))
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            perf_q <= '0;
        else
            perf_q <= perf_d;
    end

    assign StallCycles = perf_q;
`endif

endmodule
